// File: rtl/spi_pkg.sv
// ============================================================================
// Module      : spi_pkg
// Description : Shared constants for the SPI memory transaction controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

    localparam int BYTE_BITS_DEFAULT = 8;

    // Polarity of shift register bit 0 that requests a memory read
    localparam logic RW_READ = 1'b1;

    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE         = 4'd0;
    localparam logic [STATE_W-1:0] ST_GET          = 4'd1;
    localparam logic [STATE_W-1:0] ST_GOT          = 4'd2;
    localparam logic [STATE_W-1:0] ST_READ_WAIT    = 4'd3;
    localparam logic [STATE_W-1:0] ST_READ_LOAD    = 4'd4;
    localparam logic [STATE_W-1:0] ST_READ_SHIFT   = 4'd5;
    localparam logic [STATE_W-1:0] ST_WRITE        = 4'd6;
    localparam logic [STATE_W-1:0] ST_WRITE_COMMIT = 4'd7;
    localparam logic [STATE_W-1:0] ST_DONE         = 4'd8;

endpackage

`default_nettype wire

// File: rtl/spi_bit_counter.sv
// ============================================================================
// Module      : spi_bit_counter
// Description : Bit counter shared by every SPI field; flags the last bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int BYTE_BITS = BYTE_BITS_DEFAULT
) (
    input  logic clk,
    input  logic resetN,
    input  logic clear,
    input  logic incr,
    output logic terminal
);

    localparam int CNT_W = $clog2(BYTE_BITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTE_BITS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        terminal = incr && (count_q == LAST);
        count_d  = count_q;
        if (clear || terminal) begin
            count_d = '0;
        end else if (incr) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/spi_control_fsm.sv
// ============================================================================
// Module      : spi_control_fsm
// Description : Moore transaction controller for the SPI memory datapath.
//               SPI_FSM_DEBUG_EN adds fsmState / txnCount observation ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_control_fsm
    import spi_pkg::*;
#(
    parameter int BYTE_BITS = BYTE_BITS_DEFAULT
) (
    input  logic clk,
    input  logic resetN,
    input  logic sClkPosEdge,
    input  logic sClkNegEdge,
    input  logic csN,
    input  logic rwBit,
    output logic addrLatchEnable,
    output logic srLoadEnable,
    output logic dmWriteEnable,
    output logic misoBufferEnable
`ifdef SPI_FSM_DEBUG_EN
    ,
    output logic [STATE_W-1:0] fsmState,
    output logic [7:0]         txnCount
`endif
);

    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic               cnt_clear;
    logic               cnt_incr;
    logic               cnt_terminal;

    // Each state counts only its own strobe; csN high suppresses counting
    always_comb begin
        cnt_incr = 1'b0;
        if (!csN) begin
            case (state_q)
                ST_GET, ST_WRITE: cnt_incr = sClkPosEdge;
                ST_READ_SHIFT:    cnt_incr = sClkNegEdge;
                default:          cnt_incr = 1'b0;
            endcase
        end
        cnt_clear = csN || (state_q == ST_IDLE) || (state_q == ST_READ_LOAD);
    end

    spi_bit_counter #(
        .BYTE_BITS (BYTE_BITS)
    ) u_bit_counter (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (cnt_clear),
        .incr     (cnt_incr),
        .terminal (cnt_terminal)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (csN) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:         state_d = ST_GET;
                ST_GET:          if (cnt_terminal) state_d = ST_GOT;
                ST_GOT:          state_d = (rwBit == RW_READ) ? ST_READ_WAIT : ST_WRITE;
                ST_READ_WAIT:    state_d = ST_READ_LOAD;
                ST_READ_LOAD:    state_d = ST_READ_SHIFT;
                ST_READ_SHIFT:   if (cnt_terminal) state_d = ST_DONE;
                ST_WRITE:        if (cnt_terminal) state_d = ST_WRITE_COMMIT;
                ST_WRITE_COMMIT: state_d = ST_DONE;
                ST_DONE:         state_d = ST_DONE;
                default:         state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        addrLatchEnable  = 1'b0;
        srLoadEnable     = 1'b0;
        dmWriteEnable    = 1'b0;
        misoBufferEnable = 1'b0;
        case (state_q)
            ST_GOT:          addrLatchEnable  = 1'b1;
            ST_READ_LOAD:    srLoadEnable     = 1'b1;
            ST_READ_SHIFT:   misoBufferEnable = 1'b1;
            ST_WRITE_COMMIT: dmWriteEnable    = 1'b1;
            default: ;
        endcase
    end

`ifdef SPI_FSM_DEBUG_EN
    logic [7:0] txn_count_q;
    logic [7:0] txn_count_d;

    always_comb begin
        txn_count_d = txn_count_q;
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            txn_count_d = txn_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            txn_count_q <= '0;
        end else begin
            txn_count_q <= txn_count_d;
        end
    end

    assign fsmState = state_q;
    assign txnCount = txn_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_control_fsm.sv
// ============================================================================
// Module      : tb_spi_control_fsm
// Description : Self-checking bench for spi_control_fsm against a timeline model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_control_fsm;

    logic clk = 1'b0;
    logic resetN = 1'b0;
    logic sClkPosEdge = 1'b0;
    logic sClkNegEdge = 1'b0;
    logic csN = 1'b1;
    logic rwBit = 1'b0;
    logic addrLatchEnable;
    logic srLoadEnable;
    logic dmWriteEnable;
    logic misoBufferEnable;
`ifdef SPI_FSM_DEBUG_EN
    logic [3:0] fsmState;
    logic [7:0] txnCount;
`endif

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_control_fsm #(
        .BYTE_BITS (8)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .sClkPosEdge      (sClkPosEdge),
        .sClkNegEdge      (sClkNegEdge),
        .csN              (csN),
        .rwBit            (rwBit),
        .addrLatchEnable  (addrLatchEnable),
        .srLoadEnable     (srLoadEnable),
        .dmWriteEnable    (dmWriteEnable),
        .misoBufferEnable (misoBufferEnable)
`ifdef SPI_FSM_DEBUG_EN
        ,
        .fsmState         (fsmState),
        .txnCount         (txnCount)
`endif
    );

    // Transaction timeline model: per chip-select window it records the clk
    // index at which each field completes and derives every enable from that.
    bit         active;
    bit         have_addr;
    bit         have_data;
    bit         have_neg;
    bit         rw;
    int         npos;
    int         ndat;
    int         nneg;
    int         cyc;
    int         t_addr;
    int         t_data;
    int         t_neg;
    int         txn_exp;
    logic [7:0] sr;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        active    = 1'b0;
        have_addr = 1'b0;
        have_data = 1'b0;
        have_neg  = 1'b0;
        txn_exp   = 0;
    endtask

    task automatic model_edge(input bit cs, input bit p, input bit n, input bit r);
        cyc++;
        if (cs) begin
            active = 1'b0;
        end else if (!active) begin
            active    = 1'b1;
            have_addr = 1'b0;
            have_data = 1'b0;
            have_neg  = 1'b0;
            rw        = 1'b0;
            npos      = 0;
            ndat      = 0;
            nneg      = 0;
        end else if (!have_addr) begin
            if (p) begin
                npos++;
                if (npos == 8) begin
                    have_addr = 1'b1;
                    t_addr    = cyc;
                end
            end
        end else begin
            if (cyc == t_addr + 1) rw = r;
            if (cyc >= t_addr + 2 && !rw && !have_data && p) begin
                ndat++;
                if (ndat == 8) begin
                    have_data = 1'b1;
                    t_data    = cyc;
                end
            end
            if (cyc >= t_addr + 4 && rw && !have_neg && n) begin
                nneg++;
                if (nneg == 8) begin
                    have_neg = 1'b1;
                    t_neg    = cyc;
                end
            end
            if ((have_data && cyc == t_data + 1) || (have_neg && cyc == t_neg))
                txn_exp = (txn_exp + 1) % 256;
        end
    endtask

    task automatic check_outputs();
        bit e_ale;
        bit e_ld;
        bit e_we;
        bit e_miso;
        e_ale  = active && have_addr && (cyc == t_addr);
        e_ld   = active && have_addr && rw && (cyc == t_addr + 2);
        e_we   = active && have_data && (cyc == t_data);
        e_miso = active && have_addr && rw && (cyc >= t_addr + 3) && (!have_neg || cyc < t_neg);
        check_eq("addrLatchEnable", 8'(addrLatchEnable), 8'(e_ale));
        check_eq("srLoadEnable", 8'(srLoadEnable), 8'(e_ld));
        check_eq("dmWriteEnable", 8'(dmWriteEnable), 8'(e_we));
        check_eq("misoBufferEnable", 8'(misoBufferEnable), 8'(e_miso));
`ifdef SPI_FSM_DEBUG_EN
        check_eq("txnCount", txnCount, 8'(txn_exp));
`endif
    endtask

    // One clk cycle: drive at negedge, model at posedge, check just after it.
    task automatic step(input bit cs, input bit p, input bit n, input bit m);
        @(negedge clk);
        csN         = cs;
        sClkPosEdge = p;
        sClkNegEdge = n;
        @(posedge clk);
        if (resetN) model_edge(cs, p, n, rwBit);
        #1;
        if (p) sr = {sr[6:0], m};
        rwBit = sr[0];
        check_outputs();
    endtask

    task automatic send_bits(input logic [7:0] b, input int k);
        for (int i = 7; i > 7 - k; i--) begin
            step(1'b0, 1'b1, 1'b0, b[i]);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic negs(input int k);
        for (int i = 0; i < k; i++) begin
            step(1'b0, 1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic deselect(input int k);
        for (int i = 0; i < k; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic hold(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        sr  = 8'h00;
        cyc = 0;
        model_reset();

        // Reset held with chip selected and strobes toggling
        for (int i = 0; i < 4; i++) step(1'b0, i[0], ~i[0], 1'b1);
        resetN = 1'b1;
        deselect(4);

        // Read of address 0x2A: byte 0x55 carries R/W=1 in bit 0
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(8'h55, 8);
        hold(4);
        negs(8);
        deselect(3);

        // Write of address 0x15: byte 0x2A carries R/W=0
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(8'h2A, 8);
        hold(1);
        send_bits(8'(($urandom)), 8);
        hold(2);
        deselect(3);

        // Abort during address capture, then a full read must still need 8 edges
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(8'h55, 4);
        deselect(2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(8'hAB, 8);
        hold(4);
        negs(8);
        deselect(2);

        // Abort during MISO shift
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(8'h55, 8);
        hold(4);
        negs(3);
        deselect(3);

        // Asynchronous reset while MISO is driven
        step(1'b0, 1'b0, 1'b0, 1'b0);
        send_bits(8'h55, 8);
        hold(4);
        negs(2);
        @(negedge clk);
        resetN = 1'b0;
        #1;
        check_eq("rst_miso", 8'(misoBufferEnable), 8'h00);
        check_eq("rst_ale", 8'(addrLatchEnable), 8'h00);
        check_eq("rst_ld", 8'(srLoadEnable), 8'h00);
        check_eq("rst_we", 8'(dmWriteEnable), 8'h00);
`ifdef SPI_FSM_DEBUG_EN
        check_eq("rst_state", 8'(fsmState), 8'h00);
`endif
        model_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1);
        resetN = 1'b1;
        deselect(3);

        // Randomised transactions with overlapping strobes and early deselects
        for (int t = 0; t < 150; t++) begin
            int len;
            len = $urandom_range(4, 90);
            for (int i = 0; i < len; i++)
                step(1'b0, 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 9) < 4),
                     1'($urandom_range(0, 1)));
            deselect($urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spi_control_fsm.md
# spi_control_fsm

Transaction controller for the SPI memory datapath. Consumes the conditioned serial-clock edge strobes and chip select, plus bit 0 of the 8-bit shift register's parallel output (the R/W flag). Sequences address capture, data-memory read/write and MISO drive by issuing the shift register's `parallelLoad` and the address-latch, data-memory and MISO-buffer enables. It sits directly downstream of the shift register and input conditioners, and upstream of the address latch, data memory and MISO tri-state buffer.

## Interface
- `BYTE_BITS`, default 8: bits per SPI field (address+R/W byte, data byte).
- `clk`  in  1: system clock, same domain as the shift register.
- `resetN`  in  1: asynchronous, active-low reset.
- `sClkPosEdge`  in  1: one-`clk` strobe per serial-clock rising edge.
- `sClkNegEdge`  in  1: one-`clk` strobe per serial-clock falling edge.
- `csN`  in  1: conditioned chip select, active low.
- `rwBit`  in  1: shift register `parallelDataOut[0]`; 1 = read, 0 = write.
- `addrLatchEnable`  out  1: load address latch from shift register bits [7:1].
- `srLoadEnable`  out  1: drives the shift register `parallelLoad`.
- `dmWriteEnable`  out  1: data-memory write strobe.
- `misoBufferEnable`  out  1: MISO tri-state enable.

## Operation
- Moore machine. All outputs are decoded from the registered state only.
- States and transitions:
  - IDLE: `csN`=0 → GET, counter cleared.
  - GET: counts `sClkPosEdge`. The 8th edge (count==7 and strobe) → GOT.
  - GOT: `addrLatchEnable`=1. `rwBit`=1 → READ_WAIT, else → WRITE.
  - READ_WAIT: no outputs (one cycle of memory read latency) → READ_LOAD.
  - READ_LOAD: `srLoadEnable`=1 → READ_SHIFT, counter cleared.
  - READ_SHIFT: `misoBufferEnable`=1. Counts `sClkNegEdge`. The 8th edge → DONE.
  - WRITE: counts `sClkPosEdge`. The 8th edge → WRITE_COMMIT.
  - WRITE_COMMIT: `dmWriteEnable`=1 → DONE.
  - DONE: all outputs 0. Waits for `csN`=1.
- From any state, `csN`=1 → IDLE on the next `clk` edge with the counter cleared. This has priority over all edge strobes.
- Bit counter: `$clog2(BYTE_BITS)` bits. It wraps 7→0 on the same edge that leaves the counting state.
- Edge strobes in IDLE, GOT, READ_WAIT, READ_LOAD, WRITE_COMMIT and DONE are ignored.
- If `sClkPosEdge` and `sClkNegEdge` arrive in the same cycle, each is evaluated only by the state that counts it.

## Timing
- Reset: state IDLE, counter 0, all four outputs 0.
- `csN` falling → GET one `clk` later.
- `rwBit` is sampled in GOT, one cycle after the 8th address posedge. The shift register has updated by then.
- `addrLatchEnable`, `srLoadEnable` and `dmWriteEnable` are each exactly one `clk` wide per transaction.
- Read path latency: last address posedge to `srLoadEnable` high is 3 `clk` cycles (GOT, READ_WAIT, READ_LOAD).
- `misoBufferEnable` rises the cycle after `srLoadEnable`. It falls the cycle after the 8th `sClkNegEdge`, or the cycle after `csN` rises.
- Reset asserted mid-transaction: outputs drop to 0 immediately (asynchronous), and the state returns to IDLE.

## Configuration
- `SPI_FSM_DEBUG_EN` defined:
  - Adds output `fsmState` (4 bits, registered state encoding) and output `txnCount` (8 bits).
  - `txnCount` increments on entry to DONE, wraps 255→0, and resets to 0.
- Undefined: neither port exists and no counter logic is generated. All other behaviour is identical.

## Structure
- Shared package `spi_pkg` holds:
  - state encodings (IDLE=0 … DONE=8, 4-bit);
  - `BYTE_BITS` default;
  - the R/W polarity constant `RW_READ`=1.
- One sub-module, `spi_bit_counter`. It has clear and increment inputs and a `terminal` output that is high when count==`BYTE_BITS`-1 and increment=1. It is instantiated once and shared by GET, WRITE and READ_SHIFT.

## Test plan
- Reset: assert `resetN`=0 with `csN`=0 and strobes toggling → all outputs 0. After release, the machine stays in IDLE until `csN` is seen low.
- Read: `csN`=0, shift address 7'h2A with R/W=1 over 8 posedges:
  - `addrLatchEnable` pulses one cycle later;
  - `srLoadEnable` pulses 3 cycles after the 8th posedge;
  - `misoBufferEnable` is high for exactly 8 negedges, then 0 in DONE.
- Write: address 7'h15 with R/W=0, then 8 data posedges:
  - `dmWriteEnable` pulses exactly once, one cycle after the 8th data posedge;
  - `misoBufferEnable` is never asserted.
- Abort during GET: `csN`=1 after 4 posedges → IDLE next cycle with no enables pulsed. The next transaction needs a full 8 posedges to reach GOT.
- Abort during READ_SHIFT: `csN`=1 after 3 negedges → `misoBufferEnable` is 0 the next cycle. No `dmWriteEnable` is issued.
- Strobes while `csN`=1 → no state change and no output activity. Under `SPI_FSM_DEBUG_EN`, `txnCount` increments by exactly 1 per completed transaction.
